// File: rtl/usb_rx_control_fsm.sv
// ---------------------------------------------------------------------------
// usb_rx_control_fsm
// Receive-side control FSM for the USB full-speed endpoint. Consumes bytes
// from the receive shifter (already NRZI-decoded and unstuffed), checks SYNC
// and PID, and for DATA packets holds back the last two bytes (the CRC-16)
// in a 2-byte pipeline so that only true payload bytes reach the RX FIFO.
//
// Optional feature macro: RX_TIMEOUT_EN
//   defined   : 8-bit idle-bit watchdog aborts a stalled packet after
//               TIMEOUT_CYCLES cycles without a shift_strobe.
//   undefined : no watchdog; a stalled bus waits for eop or i_rst.
//
// Ports
//   i_clk           system clock
//   i_rst           synchronous reset, active high
//   i_d_edge        bus activity seen while idle (start of packet)
//   i_shift_strobe  one pulse per received unstuffed bit
//   i_rcv_data      shifter byte, valid with every 8th strobe
//   i_eop           SE0 on the bus
//   i_crc_ok        CRC-16 residual good, sampled at eop
//   o_crc_clear     pulse: reset the CRC-16 checker
//   o_crc_enable    qualifies strobes into the CRC checker (payload only)
//   o_r_enable      FIFO write strobe
//   o_r_data        payload byte for the FIFO
//   o_rcv_busy      reception in progress
//   o_rx_packet     00 none, 01 DATA, 10 ACK, 11 NAK
//   o_rx_done       pulse: packet accepted
//   o_rx_error      sticky error, cleared by the next accepted d_edge
// ---------------------------------------------------------------------------
module usb_rx_control_fsm #(
    parameter int MAX_DATA_BYTES = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_d_edge,
    input  logic       i_shift_strobe,
    input  logic [7:0] i_rcv_data,
    input  logic       i_eop,
    input  logic       i_crc_ok,
    output logic       o_crc_clear,
    output logic       o_crc_enable,
    output logic       o_r_enable,
    output logic [7:0] o_r_data,
    output logic       o_rcv_busy,
    output logic [1:0] o_rx_packet,
    output logic       o_rx_done,
    output logic       o_rx_error
);

    // state      | meaning
    // S_IDLE     | bus idle, waiting for d_edge
    // S_SYNC     | receiving the SYNC byte
    // S_PID      | receiving the PID byte
    // S_PAYLOAD  | DATA body bytes (payload + 2 CRC bytes)
    // S_HANDSHAKE| ACK/NAK received, expecting eop only
    // S_EOP_WAIT | good packet, waiting for SE0 to end
    // S_DONE     | issue rx_done
    // S_ERR_WAIT | bad packet, waiting for eop high then low

    localparam logic [7:0] LP_SYNC     = 8'h01;
    localparam logic [7:0] LP_PID_DATA = 8'h3C;
    localparam logic [7:0] LP_PID_ACK  = 8'hB4;
    localparam logic [7:0] LP_PID_NAK  = 8'hA5;

    localparam logic [1:0] LP_PKT_NONE = 2'b00;
    localparam logic [1:0] LP_PKT_DATA = 2'b01;
    localparam logic [1:0] LP_PKT_ACK  = 2'b10;
    localparam logic [1:0] LP_PKT_NAK  = 2'b11;

    // body bytes allowed = payload limit + the two CRC bytes
    localparam logic [6:0] LP_BYTE_LIMIT = 7'(MAX_DATA_BYTES + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_PAYLOAD,
        S_HANDSHAKE,
        S_EOP_WAIT,
        S_DONE,
        S_ERR_WAIT
    } state_t;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_byte_cnt;
    logic [7:0] r_hold0;
    logic [7:0] r_hold1;
    logic       r_eop_q;
    logic       r_eop_seen;
    logic       r_tmo_exit;

    logic       w_strobe;
    logic       w_byte_done;
    logic       w_eop_rise;
    logic [6:0] w_byte_cnt_nxt;
    logic       w_pid_ok;
    logic       w_timeout;
    logic       w_go_err;

    // eop wins over a coincident strobe: such a strobe is dropped entirely
    assign w_strobe       = i_shift_strobe & ~i_eop;
    assign w_byte_done    = w_strobe & (r_bit_cnt == 3'd7);
    assign w_eop_rise     = i_eop & ~r_eop_q;
    assign w_byte_cnt_nxt = r_byte_cnt + 7'd1;
    assign w_pid_ok       = (i_rcv_data == LP_PID_DATA) ||
                            (i_rcv_data == LP_PID_ACK)  ||
                            (i_rcv_data == LP_PID_NAK);

`ifdef RX_TIMEOUT_EN
    localparam logic [7:0] LP_WDOG_LOAD = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wdog_cnt;
    logic       w_wdog_active;

    assign w_wdog_active = (r_state == S_SYNC)    || (r_state == S_PID) ||
                           (r_state == S_PAYLOAD) || (r_state == S_HANDSHAKE);

    // down-counter reloaded on every strobe and while outside the packet
    // states; terminal count with no strobe is a stall
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdog_cnt <= 8'd0;
        end else if (!w_wdog_active || i_shift_strobe) begin
            r_wdog_cnt <= LP_WDOG_LOAD;
        end else if (r_wdog_cnt != 8'd0) begin
            r_wdog_cnt <= r_wdog_cnt - 8'd1;
        end
    end

    assign w_timeout = w_wdog_active & ~i_shift_strobe & (r_wdog_cnt == 8'd0);
`else
    // watchdog compiled out; the parameter stays for a uniform interface
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_go_err = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (w_eop_rise)
                    w_go_err = 1'b1;
                else if (w_byte_done && (i_rcv_data != LP_SYNC))
                    w_go_err = 1'b1;
            end
            S_PID: begin
                if (w_eop_rise)
                    w_go_err = 1'b1;
                else if (w_byte_done && !w_pid_ok)
                    w_go_err = 1'b1;
            end
            S_PAYLOAD: begin
                if (w_eop_rise)
                    w_go_err = !((r_bit_cnt == 3'd0) && (r_byte_cnt >= 7'd2) && i_crc_ok);
                else if (w_byte_done && (w_byte_cnt_nxt > LP_BYTE_LIMIT))
                    w_go_err = 1'b1;
            end
            S_HANDSHAKE: begin
                if (w_eop_rise)
                    w_go_err = (r_bit_cnt != 3'd0);
                else if (w_byte_done)
                    w_go_err = 1'b1;
            end
            default: w_go_err = 1'b0;
        endcase
        if (w_timeout)
            w_go_err = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 3'd0;
            r_byte_cnt   <= 7'd0;
            r_hold0      <= 8'd0;
            r_hold1      <= 8'd0;
            r_eop_q      <= 1'b0;
            r_eop_seen   <= 1'b0;
            r_tmo_exit   <= 1'b0;
            o_crc_clear  <= 1'b0;
            o_crc_enable <= 1'b0;
            o_r_enable   <= 1'b0;
            o_r_data     <= 8'd0;
            o_rcv_busy   <= 1'b0;
            o_rx_packet  <= LP_PKT_NONE;
            o_rx_done    <= 1'b0;
            o_rx_error   <= 1'b0;
        end else begin
            o_crc_clear  <= 1'b0;
            o_r_enable   <= 1'b0;
            o_rx_done    <= 1'b0;
            o_crc_enable <= (r_state == S_PAYLOAD) & w_strobe;
            r_eop_q      <= i_eop;

            if (w_strobe)
                r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_go_err) begin
                r_state     <= S_ERR_WAIT;
                o_rx_error  <= 1'b1;
                o_rx_packet <= LP_PKT_NONE;
                // an eop already high on entry counts as the "seen high" half
                r_eop_seen  <= i_eop;
                r_tmo_exit  <= w_timeout;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_d_edge) begin
                            r_state     <= S_SYNC;
                            r_bit_cnt   <= 3'd0;
                            o_rcv_busy  <= 1'b1;
                            o_rx_error  <= 1'b0;
                            o_rx_packet <= LP_PKT_NONE;
                        end
                    end
                    S_SYNC: begin
                        if (w_byte_done) begin
                            r_state     <= S_PID;
                            o_crc_clear <= 1'b1;
                        end
                    end
                    S_PID: begin
                        if (w_byte_done) begin
                            if (i_rcv_data == LP_PID_DATA) begin
                                r_state     <= S_PAYLOAD;
                                o_rx_packet <= LP_PKT_DATA;
                                r_byte_cnt  <= 7'd0;
                                r_hold0     <= 8'd0;
                                r_hold1     <= 8'd0;
                            end else if (i_rcv_data == LP_PID_ACK) begin
                                r_state     <= S_HANDSHAKE;
                                o_rx_packet <= LP_PKT_ACK;
                            end else begin
                                r_state     <= S_HANDSHAKE;
                                o_rx_packet <= LP_PKT_NAK;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_eop_rise) begin
                            r_state <= S_EOP_WAIT;
                        end else if (w_byte_done) begin
                            r_hold0    <= i_rcv_data;
                            r_hold1    <= r_hold0;
                            r_byte_cnt <= w_byte_cnt_nxt;
                            // the byte pushed out of hold1 can no longer be CRC
                            if (w_byte_cnt_nxt >= 7'd3) begin
                                o_r_enable <= 1'b1;
                                o_r_data   <= r_hold1;
                            end
                        end
                    end
                    S_HANDSHAKE: begin
                        if (w_eop_rise)
                            r_state <= S_EOP_WAIT;
                    end
                    S_EOP_WAIT: begin
                        if (!i_eop)
                            r_state <= S_DONE;
                    end
                    S_DONE: begin
                        o_rx_done  <= 1'b1;
                        o_rcv_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                    S_ERR_WAIT: begin
                        if (i_eop)
                            r_eop_seen <= 1'b1;
                        if (r_tmo_exit || (r_eop_seen && !i_eop)) begin
                            r_state    <= S_IDLE;
                            o_rcv_busy <= 1'b0;
                            r_tmo_exit <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        o_rcv_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_control_fsm.sv
module tb_usb_rx_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_edge;
    logic       strobe;
    logic [7:0] rcv_data;
    logic       eop;
    logic       crc_ok;
    logic       crc_clear;
    logic       crc_enable;
    logic       r_enable;
    logic [7:0] r_data;
    logic       rcv_busy;
    logic [1:0] rx_packet;
    logic       rx_done;
    logic       rx_error;

    always #5 clk = ~clk;

    usb_rx_control_fsm dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_d_edge       (d_edge),
        .i_shift_strobe (strobe),
        .i_rcv_data     (rcv_data),
        .i_eop          (eop),
        .i_crc_ok       (crc_ok),
        .o_crc_clear    (crc_clear),
        .o_crc_enable   (crc_enable),
        .o_r_enable     (r_enable),
        .o_r_data       (r_data),
        .o_rcv_busy     (rcv_busy),
        .o_rx_packet    (rx_packet),
        .o_rx_done      (rx_done),
        .o_rx_error     (rx_error)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int row_wr, row_done, row_clr, row_crcen;

    typedef struct {
        logic [7:0] sync;
        logic [7:0] pid;
        int         nbody;
        int         part;
        logic       crc;
        logic [1:0] pkt;
        int         done;
        int         err;
        int         wr;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // scoreboard: every FIFO write must match the oldest expected byte
    always @(negedge clk) begin
        if (r_enable) begin
            row_wr++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got data %0h expected no write", r_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (r_data !== mon_exp) begin
                    errors++;
                    $display("FAIL r_data: got %0h expected %0h", r_data, mon_exp);
                end
            end
        end
        if (rx_done)    row_done++;
        if (crc_clear)  row_clr++;
        if (crc_enable) row_crcen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits);
        rcv_data = b;
        for (int i = 0; i < nbits; i++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            tick();
        end
    endtask

    task automatic do_eop(input logic crc);
        eop    = 1'b1;
        crc_ok = crc;
        tick();
        tick();
        eop    = 1'b0;
        crc_ok = 1'b0;
        repeat (4) tick();
    endtask

    task automatic start_pkt();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] body_byte(input int k, input int n);
        if (k == n - 2) return 8'hA1;
        if (k == n - 1) return 8'hB2;
        return 8'((k + 1) * 17);
    endfunction

    // body byte k displaces byte k-2 into the FIFO, up to 64 payload bytes
    task automatic send_body(input int nbody, input bit is_data);
        for (int k = 0; k < nbody; k++) begin
            if (is_data && k >= 2 && k <= 65)
                exp_q.push_back(body_byte(k - 2, nbody));
            send_byte(body_byte(k, nbody), 8);
        end
    endtask

    initial begin
        bit is_data;

        vecs[0]  = '{8'h01, 8'h3C,  6, 0, 1'b1, 2'b01, 1, 0,  4};
        vecs[1]  = '{8'h01, 8'hB4,  0, 0, 1'b1, 2'b10, 1, 0,  0};
        vecs[2]  = '{8'h01, 8'hA5,  0, 0, 1'b1, 2'b11, 1, 0,  0};
        vecs[3]  = '{8'h03, 8'hB4,  0, 0, 1'b1, 2'b00, 0, 1,  0};
        vecs[4]  = '{8'h01, 8'hB4,  0, 0, 1'b1, 2'b10, 1, 0,  0};
        vecs[5]  = '{8'h01, 8'h3C,  6, 0, 1'b0, 2'b00, 0, 1,  4};
        vecs[6]  = '{8'h01, 8'h3C,  4, 5, 1'b1, 2'b00, 0, 1,  2};
        vecs[7]  = '{8'h01, 8'h3C, 66, 0, 1'b1, 2'b01, 1, 0, 64};
        vecs[8]  = '{8'h01, 8'h3C, 67, 0, 1'b1, 2'b00, 0, 1, 64};
        vecs[9]  = '{8'h01, 8'h77,  0, 0, 1'b1, 2'b00, 0, 1,  0};
        vecs[10] = '{8'h01, 8'hB4,  1, 0, 1'b1, 2'b00, 0, 1,  0};
        vecs[11] = '{8'h01, 8'h3C,  2, 0, 1'b1, 2'b01, 1, 0,  0};
        vecs[12] = '{8'h01, 8'h3C,  1, 0, 1'b1, 2'b00, 0, 1,  0};
        vecs[13] = '{8'h01, 8'hA5,  0, 3, 1'b1, 2'b00, 0, 1,  0};

        rst = 1'b1; d_edge = 1'b0; strobe = 1'b0; rcv_data = 8'h00;
        eop = 1'b0; crc_ok = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy",    int'(rcv_busy),  0);
        chk("reset_packet",  int'(rx_packet), 0);
        chk("reset_error",   int'(rx_error),  0);
        chk("reset_done",    int'(rx_done),   0);
        chk("reset_renable", int'(r_enable),  0);
        chk("reset_crcclr",  int'(crc_clear), 0);
        tick();

        for (int r = 0; r < 14; r++) begin
            is_data   = (vecs[r].sync == 8'h01) && (vecs[r].pid == 8'h3C);
            row_wr = 0; row_done = 0; row_clr = 0; row_crcen = 0;
            start_pkt();
            send_byte(vecs[r].sync, 8);
            send_byte(vecs[r].pid, 8);
            send_body(vecs[r].nbody, is_data);
            if (vecs[r].part > 0)
                send_byte(8'h00, vecs[r].part);
            do_eop(vecs[r].crc);
            @(negedge clk);
            chk($sformatf("row%0d_writes", r),  row_wr,          vecs[r].wr);
            chk($sformatf("row%0d_done", r),    row_done,        vecs[r].done);
            chk($sformatf("row%0d_error", r),   int'(rx_error),  vecs[r].err);
            chk($sformatf("row%0d_packet", r),  int'(rx_packet), int'(vecs[r].pkt));
            chk($sformatf("row%0d_busy", r),    int'(rcv_busy),  0);
            chk($sformatf("row%0d_crcclr", r),  row_clr,         (vecs[r].sync == 8'h01) ? 1 : 0);
            chk($sformatf("row%0d_crcen", r),   row_crcen,
                is_data ? 8 * vecs[r].nbody + vecs[r].part : 0);
            chk($sformatf("row%0d_q_empty", r), exp_q.size(),    0);
            tick();
        end

        // crc_clear and rx_done cycle timing on a NAK
        start_pkt();
        send_byte(8'h01, 7);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        @(negedge clk);
        chk("crcclr_pulse_hi", int'(crc_clear), 1);
        tick();
        @(negedge clk);
        chk("crcclr_pulse_lo", int'(crc_clear), 0);
        tick();
        send_byte(8'hA5, 8);
        eop = 1'b1; crc_ok = 1'b1;
        tick();
        tick();
        eop = 1'b0; crc_ok = 1'b0;
        @(negedge clk);
        chk("done_t0", int'(rx_done), 0);
        @(negedge clk);
        chk("done_t1", int'(rx_done), 0);
        @(negedge clk);
        chk("done_t2", int'(rx_done), 1);
        chk("done_t2_packet", int'(rx_packet), 3);
        @(negedge clk);
        chk("done_t3", int'(rx_done), 0);
        tick();

        // rx_error one cycle after a bad SYNC byte
        start_pkt();
        send_byte(8'h03, 7);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        @(negedge clk);
        chk("err_latency", int'(rx_error), 1);
        tick();
        do_eop(1'b0);

        // reset mid-payload
        start_pkt();
        send_byte(8'h01, 8);
        send_byte(8'h3C, 8);
        for (int k = 0; k < 5; k++) begin
            if (k >= 2) exp_q.push_back(body_byte(k - 2, 7));
            send_byte(body_byte(k, 7), 8);
        end
        chk("prerst_q_empty", exp_q.size(), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy",    int'(rcv_busy),  0);
        chk("midrst_packet",  int'(rx_packet), 0);
        chk("midrst_renable", int'(r_enable),  0);
        chk("midrst_crcen",   int'(crc_enable), 0);
        tick();
        send_byte(8'h55, 8);
        repeat (10) tick();
        @(negedge clk);
        chk("postrst_busy", int'(rcv_busy), 0);
        tick();

        // stalled bus inside PAYLOAD
        row_wr = 0;
        start_pkt();
        send_byte(8'h01, 8);
        send_byte(8'h3C, 8);
        send_body(3, 1'b1);
`ifdef RX_TIMEOUT_EN
        repeat (250) tick();
        @(negedge clk);
        chk("tmo_not_yet", int'(rx_error), 0);
        tick();
        repeat (10) tick();
        @(negedge clk);
        chk("tmo_error",  int'(rx_error),  1);
        chk("tmo_idle",   int'(rcv_busy),  0);
        chk("tmo_packet", int'(rx_packet), 0);
        tick();
`else
        repeat (300) tick();
        @(negedge clk);
        chk("stall_busy",  int'(rcv_busy), 1);
        chk("stall_error", int'(rx_error), 0);
        tick();
        do_eop(1'b0);
        @(negedge clk);
        chk("stall_eop_error", int'(rx_error), 1);
        tick();
`endif
        chk("stall_writes", row_wr, 1);
        chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_rx_control_fsm.md
# usb_rx_control_fsm

Receive-side control FSM for the USB full-speed endpoint; the counterpart of the transmit control FSM. It consumes bits already NRZI-decoded, bit-unstuffed and assembled by the receive shifter. It validates SYNC and PID, then strips the two CRC bytes from DATA payloads through a 2-byte holding pipeline. Only true payload bytes are written to the RX FIFO, and the packet type and done/error status go to the AHB-side protocol logic.

## Interface
Parameters:
- MAX_DATA_BYTES, 64, largest accepted payload (CRC bytes excluded)
- TIMEOUT_CYCLES, 255, idle-bit watchdog limit (used only with RX_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- d_edge  in  1  D+ transition seen while bus idle (start of packet)
- shift_strobe  in  1  one-cycle pulse per received unstuffed bit
- rcv_data  in  8  shifter byte; valid in the cycle of every 8th shift_strobe
- eop  in  1  high while SE0 is sampled on the bus
- crc_ok  in  1  CRC-16 checker residual matches; sampled at EOP
- crc_clear  out  1  one-cycle pulse to reset the CRC-16 checker
- crc_enable  out  1  qualifies shift_strobe into the CRC checker
- r_enable  out  1  one-cycle FIFO write strobe
- r_data  out  8  payload byte for the FIFO; valid while r_enable is high
- rcv_busy  out  1  packet reception in progress
- rx_packet  out  2  00 none, 01 DATA, 10 ACK, 11 NAK; held until next start
- rx_done  out  1  one-cycle pulse, packet accepted
- rx_error  out  1  sticky; cleared by next accepted d_edge or rst

## Operation
- Constants: SYNC 8'h01, PID DATA 8'h3C, ACK 8'hB4, NAK 8'hA5.
- 3-bit bit_cnt increments on shift_strobe and wraps at 7. A byte completes on a strobe with bit_cnt==7.
- bit_cnt clears on entry to SYNC.
- IDLE: on d_edge -> SYNC. Also: rcv_busy=1, rx_error=0, rx_packet=00.
- SYNC: on byte complete, rcv_data==SYNC -> PID, else -> ERR_WAIT. crc_clear pulses on the SYNC->PID transition.
- PID: on byte complete:
  - DATA -> PAYLOAD
  - ACK/NAK -> HANDSHAKE
  - any other value -> ERR_WAIT
  - rx_packet is set on this transition.
- PAYLOAD: crc_enable=shift_strobe. Each completed byte shifts through hold0 -> hold1 -> out.
  - Once the byte count is ≥3, every completed byte also writes the displaced hold1 byte as r_data with r_enable.
  - byte_cnt (7 bits) counts all body bytes. byte_cnt exceeding MAX_DATA_BYTES+2 -> ERR_WAIT.
  - On eop rising: requires bit_cnt==0, byte_cnt≥2 and crc_ok, -> EOP_WAIT; otherwise -> ERR_WAIT.
  - hold0/hold1 (the CRC bytes) are discarded.
- HANDSHAKE: byte complete -> ERR_WAIT. On eop rising with bit_cnt==0 -> EOP_WAIT; with bit_cnt≠0 -> ERR_WAIT.
- Stray eop: eop rising in SYNC or PID -> ERR_WAIT.
- EOP_WAIT: on eop low -> DONE.
- DONE: rx_done=1 for one cycle -> IDLE.
- ERR_WAIT: rx_error=1 and rx_packet=00 on entry. Stay until eop seen high then low, then -> IDLE.
  - A packet that errors mid-payload may already have written bytes. Downstream flushes on rx_error.
- rcv_busy is 1 in every state except IDLE.
- shift_strobe and eop in the same cycle: the strobe is ignored; EOP processing wins.
- d_edge outside IDLE is ignored.

## Timing
- All outputs are registered. Reset values: every output 0, state IDLE, counters and hold registers 0.
- rst mid-packet returns to IDLE on the next edge. No FIFO write occurs after reset.
- r_enable/r_data appear 1 cycle after the completing shift_strobe.
- rx_done pulses 2 cycles after eop falls: one cycle into DONE, then the registered output.
- crc_clear pulses 1 cycle after the SYNC byte completes, before the first PID bit.
- rx_error sets 1 cycle after the offending byte or eop edge.

## Configuration
- RX_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles without a shift_strobe in SYNC, PID, PAYLOAD and HANDSHAKE.
  - It resets on each strobe.
  - Reaching TIMEOUT_CYCLES -> ERR_WAIT with rx_error=1, then returns to IDLE immediately, without waiting for eop.
- RX_TIMEOUT_EN undefined: no watchdog. A stalled bus leaves the FSM in its current state until eop or rst.

## Test plan
- Sync check: d_edge, then SYNC, PID 8'h3C, body bytes 11,22,33,44, CRC bytes A1,B2, eop with crc_ok=1.
  - Expect exactly four r_enable writes 11,22,33,44, rx_packet=01, one rx_done pulse, no CRC bytes written.
- Handshake: SYNC, PID 8'hB4, eop -> rx_packet=10, rx_done, no r_enable.
  - Repeat with 8'hA5 -> rx_packet=11.
- Bad input: SYNC byte 8'h03 -> rx_error=1, rx_packet=00.
  - Then a following valid ACK packet clears rx_error and completes normally.
- CRC failure: DATA packet with crc_ok=0 at eop -> rx_error=1, no rx_done.
  - Also: eop after 5 bits of a byte -> rx_error.
- Overflow: DATA with 67 body bytes -> rx_error on the 67th byte completion.
  - Exactly 66 body bytes with crc_ok=1 -> 64 writes and rx_done.
- Reset and timeout: rst asserted mid-payload -> all outputs 0 next cycle.
  - With RX_TIMEOUT_EN, strobes stopping for 255 cycles in PAYLOAD -> rx_error, then IDLE.
